// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative signed multiply (radix-2 Booth) and divide (restoring
//            on magnitudes) unit feeding the architectural HI/LO registers.
//            One step per cycle, WIDTH steps per operation.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  // Multiplicand during MULT, divisor magnitude during DIV.
  logic [WIDTH-1:0] operand;
  // Booth product register: {upper, multiplier, q_minus_1}.
  logic [2*WIDTH:0] prod;
  // Restoring-division partial remainder and dividend/quotient shift register.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_quo;
  logic             neg_rem;

  // Operand magnitudes for division; |-2^(W-1)| is representable unsigned.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth step: the add/subtract is done one bit wider than the upper half so
  // that the most negative multiplicand cannot overflow, and that extra bit
  // becomes the sign shifted in by the arithmetic right shift.
  logic [WIDTH:0]   booth_upper;
  logic [WIDTH:0]   booth_mcand;
  logic [WIDTH:0]   booth_sum;
  logic [2*WIDTH:0] prod_next;
  assign booth_upper = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
  assign booth_mcand = {operand[WIDTH-1], operand};

  // Select add, subtract or pass-through from the current Booth bit pair.
  always_comb begin
    booth_sum = booth_upper;
    case (prod[1:0])
      2'b01:   booth_sum = booth_upper + booth_mcand;
      2'b10:   booth_sum = booth_upper - booth_mcand;
      default: booth_sum = booth_upper;
    endcase
  end

  assign prod_next = {booth_sum, prod[WIDTH:1]};

  // Restoring-division step: shift in the next dividend bit, subtract the
  // divisor when it fits. The difference is always below the divisor, so a
  // WIDTH-bit subtraction is exact.
  logic [WIDTH:0]   div_shifted;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;
  assign div_shifted = {rem, quo[WIDTH-1]};
  assign div_fits    = (div_shifted >= {1'b0, operand});
  assign div_diff    = div_shifted[WIDTH-1:0] - operand;
  assign rem_next    = div_fits ? div_diff : div_shifted[WIDTH-1:0];
  assign quo_next    = {quo[WIDTH-2:0], div_fits};
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_signed  = neg_quo ? -quo_next : quo_next;
  assign rem_signed  = neg_rem ? -rem_next : rem_next;

  assign busy = (state == MULT) || (state == DIV);

  // Control FSM, datapath registers and HI/LO commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      operand  <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult) begin
            operand  <= a;
            prod     <= {{WIDTH{1'b0}}, b, 1'b0};
            count    <= '0;
            div_zero <= 1'b0;
            state    <= MULT;
          end else if (start_div) begin
            if (b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              operand  <= b_mag;
              rem      <= '0;
              quo      <= a_mag;
              neg_quo  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem  <= a[WIDTH-1];
              count    <= '0;
              div_zero <= 1'b0;
              state    <= DIV;
            end
          end
        end
        MULT: begin
          prod  <= prod_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            hi    <= prod_next[2*WIDTH:WIDTH+1];
            lo    <= prod_next[WIDTH:1];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            hi    <= rem_signed;
            lo    <= quo_signed;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit with
//            hand-computed expected results and latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  int done_at;
  int busy_cnt;
  int done_cnt;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one start (accepted at the following rising edge), scramble the
  // operand inputs afterwards, and observe busy/done for WIDTH+5 cycles.
  // Sample index j refers to the falling edge after accept edge t0+j.
  // A start_div pulse can be injected at sample index poke_at (-1 = none).
  task automatic run_op(input logic sm, input logic sd,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int poke_at);
    @(negedge clock);
    start_mult = sm;
    start_div  = sd;
    a          = aa;
    b          = bb;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = $urandom;
    b          = $urandom;
    done_at  = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < W + 5; j++) begin
      @(negedge clock);
      start_div = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j == poke_at) begin
        start_div = 1'b1;
        a         = 32'd9;
        b         = 32'd2;
      end
    end
    start_div = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(negedge clock);
    check("reset_hi",       {32'd0, hi}, 64'd0);
    check("reset_lo",       {32'd0, lo}, 64'd0);
    check("reset_busy",     {63'd0, busy}, 64'd0);
    check("reset_done",     {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;

    // 7 * -3 = -21, with latency checks
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("mul_7x-3_hi",   {32'd0, hi}, 64'hFFFF_FFFF);
    check("mul_7x-3_lo",   {32'd0, lo}, 64'hFFFF_FFEB);
    check("mul_done_at",   64'(done_at), 64'd32);
    check("mul_busy_cnt",  64'(busy_cnt), 64'd32);
    check("mul_done_cnt",  64'(done_cnt), 64'd1);
    check("mul_div_zero",  {63'd0, div_zero}, 64'd0);

    // (-2^31) * (-2^31) = 2^62
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("mul_min_hi", {32'd0, hi}, 64'h4000_0000);
    check("mul_min_lo", {32'd0, lo}, 64'h0000_0000);

    // (2^31-1)^2 = 2^62 - 2^32 + 1
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    check("mul_max_hi", {32'd0, hi}, 64'h3FFF_FFFF);
    check("mul_max_lo", {32'd0, lo}, 64'h0000_0001);

    // -7 / 2 = -3 rem -1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_-7/2_lo",   {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_-7/2_hi",   {32'd0, hi}, 64'hFFFF_FFFF);
    check("div_done_at",   64'(done_at), 64'd32);
    check("div_busy_cnt",  64'(busy_cnt), 64'd32);

    // 7 / -2 = -3 rem 1
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, -1);
    check("div_7/-2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_7/-2_hi", {32'd0, hi}, 64'h0000_0001);

    // -2^31 / -1 wraps to -2^31 rem 0, no flag
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_min/-1_lo", {32'd0, lo}, 64'h8000_0000);
    check("div_min/-1_hi", {32'd0, hi}, 64'h0000_0000);
    check("div_min/-1_dz", {63'd0, div_zero}, 64'd0);

    // 0x451 / 0x20 = 0x22 rem 0x11 (sets up the div-by-zero hold check)
    run_op(1'b0, 1'b1, 32'h0000_0451, 32'h0000_0020, -1);
    check("div_setup_lo", {32'd0, lo}, 64'h22);
    check("div_setup_hi", {32'd0, hi}, 64'h11);

    // 5 / 0: immediate done, flag set, HI/LO untouched, never busy
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1);
    check("dz_done_at",  64'(done_at), 64'd0);
    check("dz_done_cnt", 64'(done_cnt), 64'd1);
    check("dz_busy_cnt", 64'(busy_cnt), 64'd0);
    check("dz_flag",     {63'd0, div_zero}, 64'd1);
    check("dz_hi_hold",  {32'd0, hi}, 64'h11);
    check("dz_lo_hold",  {32'd0, lo}, 64'h22);

    // Following valid mult clears the flag
    run_op(1'b1, 1'b0, 32'd2, 32'd3, -1);
    check("dz_clear_flag", {63'd0, div_zero}, 64'd0);
    check("dz_clear_lo",   {32'd0, lo}, 64'd6);

    // Simultaneous starts: mult wins; a start_div mid-mult is ignored
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 5);
    check("both_hi",       {32'd0, hi}, 64'd0);
    check("both_lo",       {32'd0, lo}, 64'd12);
    check("both_done_cnt", 64'(done_cnt), 64'd1);
    check("both_busy_cnt", 64'(busy_cnt), 64'd32);
    check("both_dz",       {63'd0, div_zero}, 64'd0);

    // Asynchronous reset at cycle 10 of a mult
    @(negedge clock);
    start_mult = 1'b1;
    a          = 32'd100;
    b          = 32'd200;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    repeat (10) @(negedge clock);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_hi",   {32'd0, hi}, 64'd0);
    check("async_rst_lo",   {32'd0, lo}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // -5 * 6 = -30 after reset release
    run_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd6, -1);
    check("post_rst_hi",       {32'd0, hi}, 64'hFFFF_FFFF);
    check("post_rst_lo",       {32'd0, lo}, 64'hFFFF_FFE2);
    check("post_rst_done_cnt", 64'(done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle MIPS datapath, sitting directly downstream of the control FSM.
- The FSM issues a one-cycle start for mult or div with rs/rt from the A/B registers, then waits on done.
- Results land in architectural HI/LO registers, which feed the mfhi/mflo write-back mux input.
- Division by zero is flagged so the FSM can enter its exception sequence.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start_mult  in  1  one-cycle request: signed A*B.
- start_div  in  1  one-cycle request: signed A/B.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- hi  out  WIDTH  HI register (mult upper half / div remainder).
- lo  out  WIDTH  LO register (mult lower half / div quotient).
- busy  out  1  high while an operation iterates.
- done  out  1  one-cycle pulse when the result is committed.
- div_zero  out  1  last accepted div had b==0.

Behaviour:
- Reset is asynchronous, active-high; clock is clock. Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, iteration counter=0.
- Reset mid-operation aborts the operation immediately; no partial result is committed.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult=1 -> latch a, b; counter=0; go to MULT.
  - start_div=1 and b!=0 -> latch operands; go to DIV.
  - start_div=1 and b==0 -> go to DONE with div_zero set; hi/lo unchanged.
  - start_mult and start_div both high -> MULT wins; the div request is dropped.
  - Any accepted start clears div_zero, except a div-by-zero start, which sets it.
- Starts seen in MULT, DIV or DONE are ignored (no queueing).
- Operands are latched at accept; a/b changes during iteration have no effect.
- MULT:
  - Radix-2 Booth, signed two's complement, one step per cycle, WIDTH steps.
  - Internal 2*WIDTH+1-bit product register; arithmetic right shift each step.
  - After step WIDTH-1: hi <= product[2W-1:W], lo <= product[W-1:0]; go to DONE.
- DIV:
  - Restoring division on magnitudes |a|, |b| (WIDTH-bit unsigned; |-2^(W-1)| fits), one quotient bit per cycle, WIDTH steps.
  - After the last step, apply signs: quotient is negated if sign(a)!=sign(b) (truncation toward zero); remainder takes the sign of a.
  - Commit lo <= quotient, hi <= remainder; go to DONE.
  - -2^(W-1) / -1 gives lo=0x80000000, hi=0 (wraps, no flag).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 exactly while in MULT or DIV.
- Latency, with start accepted at edge t0:
  - Mult/div: busy is high cycles t0..t0+WIDTH-1; hi/lo update at edge t0+WIDTH; done is high between edges t0+WIDTH and t0+WIDTH+1.
  - Div-by-zero: done is high between t0 and t0+1; busy never asserts.
  - Earliest next accept is edge t0+WIDTH+1 (t0+1 for div-by-zero).
- hi/lo hold their previous values throughout iteration and change only at the commit edge.

Test Plan:
- Mult 7 * -3: a=7, b=0xFFFFFFFD, pulse start_mult -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses exactly once, 32 cycles after the accept edge; busy high for 32 cycles.
- Mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000. Also 0x7FFFFFFF * 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Div signs:
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Div by zero after a prior result hi=0x11, lo=0x22: a=5, b=0 -> done one cycle after accept, div_zero=1, hi/lo stay 0x11/0x22, busy stays 0. A following valid mult clears div_zero.
- Simultaneous start_mult and start_div with a=3, b=4 -> mult result hi=0, lo=12. A start_div pulsed at cycle 5 of that mult is ignored; only one done pulse appears.
- Assert reset at cycle 10 of a mult -> hi, lo, busy, done read 0 before the next clock edge. After release, the unit accepts a new start_mult and produces a correct result.
